// File: rtl/axi_b_response_router.sv
// axi_b_response_router: fans B responses from one slave port back to N target
// ports through a single registered stage, policing them with per-port
// outstanding-write counters fed at AW acceptance.
module axi_b_response_router #(
    parameter int unsigned AXI_ID_IN       = 16,
    parameter int unsigned N_TARG_PORT     = 7,
    parameter int unsigned LOG_N_TARG      = $clog2(N_TARG_PORT),
    parameter int unsigned AXI_ID_OUT      = AXI_ID_IN + LOG_N_TARG,
    parameter int unsigned AXI_USER_W      = 6,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [AXI_ID_OUT-1:0]                   bid_i,
    input  logic [1:0]                              bresp_i,
    input  logic [AXI_USER_W-1:0]                   buser_i,
    input  logic                                    bvalid_i,
    output logic                                    bready_o,
    output logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]   bid_o,
    output logic [N_TARG_PORT-1:0][1:0]             bresp_o,
    output logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]  buser_o,
    output logic [N_TARG_PORT-1:0]                  bvalid_o,
    input  logic [N_TARG_PORT-1:0]                  bready_i,
    input  logic                                    aw_push_i,
    input  logic [LOG_N_TARG-1:0]                   aw_port_i,
    output logic [N_TARG_PORT-1:0]                  outstanding_full_o,
    output logic                                    unexpected_b_o,
    output logic                                    overflow_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e                                 state_q, state_d;
    logic [LOG_N_TARG-1:0]                  sel_q, sel_d;
    logic [AXI_ID_IN-1:0]                   id_q, id_d;
    logic [1:0]                             resp_q, resp_d;
    logic [AXI_USER_W-1:0]                  user_q, user_d;
    logic [N_TARG_PORT-1:0][CNT_W-1:0]      cnt_q, cnt_d;
    logic                                   unexp_q, unexp_d;
    logic                                   ovf_q, ovf_d;

    logic [LOG_N_TARG-1:0]                  b_port;
    logic                                   b_legal;
    logic                                   b_accept;
    logic [N_TARG_PORT-1:0]                 inc_v;
    logic [N_TARG_PORT-1:0]                 dec_v;

    assign b_port   = bid_i[AXI_ID_OUT-1 -: LOG_N_TARG];
    assign b_accept = bvalid_i & bready_o;

    // Route is legal only for an existing port with a registered outstanding write
    always_comb begin
        b_legal = 1'b0;
        for (int unsigned p = 0; p < N_TARG_PORT; p++) begin
            if (b_port == LOG_N_TARG'(p) && cnt_q[p] != '0) begin
                b_legal = 1'b1;
            end
        end
    end

    // Slave-side ready: free stage, or the current holder is being drained
    always_comb begin
        bready_o = 1'b0;
        if (!rst) begin
            bready_o = (state_q == EMPTY) ? 1'b1 : bready_i[sel_q];
        end
    end

    // Output stage: drain on target handshake, reload or drop on slave acceptance
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        id_d    = id_q;
        resp_d  = resp_q;
        user_d  = user_q;
        unexp_d = 1'b0;
        if (state_q == FULL && bready_i[sel_q]) begin
            state_d = EMPTY;
        end
        if (b_accept) begin
            if (b_legal) begin
                state_d = FULL;
                sel_d   = b_port;
                id_d    = bid_i[AXI_ID_IN-1:0];
                resp_d  = bresp_i;
                user_d  = buser_i;
            end else begin
                unexp_d = 1'b1;
            end
        end
    end

    // Outstanding counters; a same-port decrement frees room for a push at the limit
    always_comb begin
        cnt_d = cnt_q;
        inc_v = '0;
        dec_v = '0;
        for (int unsigned p = 0; p < N_TARG_PORT; p++) begin
            dec_v[p] = b_accept && b_legal && (b_port == LOG_N_TARG'(p));
            inc_v[p] = aw_push_i && (aw_port_i == LOG_N_TARG'(p)) &&
                       ((cnt_q[p] != CNT_W'(MAX_OUTSTANDING)) || dec_v[p]);
            if (inc_v[p] && !dec_v[p]) begin
                cnt_d[p] = cnt_q[p] + CNT_W'(1);
            end else if (dec_v[p] && !inc_v[p]) begin
                cnt_d[p] = cnt_q[p] - CNT_W'(1);
            end
        end
        ovf_d = aw_push_i && (inc_v == '0);
    end

    // Target-side outputs driven from the stage; everything forced low in reset
    always_comb begin
        bid_o              = '0;
        bresp_o            = '0;
        buser_o            = '0;
        bvalid_o           = '0;
        outstanding_full_o = '0;
        unexpected_b_o     = 1'b0;
        overflow_o         = 1'b0;
        if (!rst) begin
            for (int unsigned p = 0; p < N_TARG_PORT; p++) begin
                bid_o[p]              = id_q;
                bresp_o[p]            = resp_q;
                buser_o[p]            = user_q;
                bvalid_o[p]           = (state_q == FULL) && (sel_q == LOG_N_TARG'(p));
                outstanding_full_o[p] = (cnt_q[p] == CNT_W'(MAX_OUTSTANDING));
            end
            unexpected_b_o = unexp_q;
            overflow_o     = ovf_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            sel_q   <= '0;
            id_q    <= '0;
            resp_q  <= '0;
            user_q  <= '0;
            cnt_q   <= '0;
            unexp_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            id_q    <= id_d;
            resp_q  <= resp_d;
            user_q  <= user_d;
            cnt_q   <= cnt_d;
            unexp_q <= unexp_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_axi_b_response_router.sv
// Self-checking bench for axi_b_response_router: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_axi_b_response_router;

    localparam int unsigned ID_IN  = 16;
    localparam int unsigned NP     = 7;
    localparam int unsigned LOGN   = 3;
    localparam int unsigned ID_OUT = ID_IN + LOGN;
    localparam int unsigned UW     = 6;
    localparam int unsigned MAXO   = 8;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [ID_OUT-1:0]             bid_i;
    logic [1:0]                    bresp_i;
    logic [UW-1:0]                 buser_i;
    logic                          bvalid_i;
    logic                          bready_o;
    logic [NP-1:0][ID_IN-1:0]      bid_o;
    logic [NP-1:0][1:0]            bresp_o;
    logic [NP-1:0][UW-1:0]         buser_o;
    logic [NP-1:0]                 bvalid_o;
    logic [NP-1:0]                 bready_i;
    logic                          aw_push_i;
    logic [LOGN-1:0]               aw_port_i;
    logic [NP-1:0]                 outstanding_full_o;
    logic                          unexpected_b_o;
    logic                          overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: at most one held response plus per-port write counts
    bit          m_full;
    int          m_port;
    logic [15:0] m_id;
    logic [1:0]  m_resp;
    logic [5:0]  m_user;
    int          m_cnt [NP];
    bit          m_unexp;
    bit          m_ovf;

    axi_b_response_router #(
        .AXI_ID_IN(ID_IN), .N_TARG_PORT(NP), .AXI_USER_W(UW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .bid_i(bid_i), .bresp_i(bresp_i), .buser_i(buser_i), .bvalid_i(bvalid_i),
        .bready_o(bready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .buser_o(buser_o), .bvalid_o(bvalid_o),
        .bready_i(bready_i),
        .aw_push_i(aw_push_i), .aw_port_i(aw_port_i),
        .outstanding_full_o(outstanding_full_o),
        .unexpected_b_o(unexpected_b_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_full  = 1'b0;
        m_port  = 0;
        m_id    = '0;
        m_resp  = '0;
        m_user  = '0;
        m_unexp = 1'b0;
        m_ovf   = 1'b0;
        for (int p = 0; p < NP; p++) m_cnt[p] = 0;
    endtask

    task automatic check_outputs();
        logic          e_ready;
        logic [NP-1:0] e_valid;
        logic [NP-1:0] e_ofull;
        e_ready = rst ? 1'b0 : (!m_full || bready_i[m_port]);
        e_valid = '0;
        if (!rst && m_full) e_valid[m_port] = 1'b1;
        for (int p = 0; p < NP; p++) e_ofull[p] = !rst && (m_cnt[p] == MAXO);
        check("bready_o", 64'(bready_o), 64'(e_ready));
        check("bvalid_o", 64'(bvalid_o), 64'(e_valid));
        check("outstanding_full_o", 64'(outstanding_full_o), 64'(e_ofull));
        check("unexpected_b_o", 64'(unexpected_b_o), 64'(!rst && m_unexp));
        check("overflow_o", 64'(overflow_o), 64'(!rst && m_ovf));
        if (rst || m_full) begin
            for (int p = 0; p < NP; p++) begin
                check("bid_o", 64'(bid_o[p]), rst ? 64'(0) : 64'(m_id));
                check("bresp_o", 64'(bresp_o[p]), rst ? 64'(0) : 64'(m_resp));
                check("buser_o", 64'(buser_o[p]), rst ? 64'(0) : 64'(m_user));
            end
        end
    endtask

    task automatic model_update();
        int bp;
        int ap;
        bit acc;
        bit legal;
        bit dec;
        if (rst) begin
            model_clear();
            return;
        end
        acc   = bvalid_i && (!m_full || bready_i[m_port]);
        bp    = int'(bid_i[ID_OUT-1 -: LOGN]);
        legal = 1'b0;
        if (bp < NP) legal = (m_cnt[bp] > 0);
        dec   = acc && legal;
        m_ovf = 1'b0;
        if (aw_push_i) begin
            ap = int'(aw_port_i);
            if (ap >= NP) m_ovf = 1'b1;
            else if (m_cnt[ap] < MAXO || (dec && bp == ap)) m_cnt[ap]++;
            else m_ovf = 1'b1;
        end
        if (dec) m_cnt[bp]--;
        if (m_full && bready_i[m_port]) m_full = 1'b0;
        m_unexp = 1'b0;
        if (acc) begin
            if (legal) begin
                m_full = 1'b1;
                m_port = bp;
                m_id   = bid_i[ID_IN-1:0];
                m_resp = bresp_i;
                m_user = buser_i;
            end else begin
                m_unexp = 1'b1;
            end
        end
    endtask

    // One cycle: inputs already applied; check mid-cycle, then advance model with DUT
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit r, input bit bv, input int port, input logic [15:0] id,
                         input logic [1:0] resp, input logic [5:0] user,
                         input logic [NP-1:0] rdy, input bit push, input int awp);
        rst       = r;
        bvalid_i  = bv;
        bid_i     = {LOGN'(port), id};
        bresp_i   = resp;
        buser_i   = user;
        bready_i  = rdy;
        aw_push_i = push;
        aw_port_i = LOGN'(awp);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 16'h0, 2'b00, 6'h0, '1, 0, 0);
    endtask

    initial begin
        logic [NP-1:0] hold2;
        hold2 = 7'b1111011;
        model_clear();
        drive(1, 1, 0, 16'h0, 2'b00, 6'h0, '1, 0, 0);
        @(posedge clk);
        #1;

        // Reset held with a pending slave response
        drive(1, 1, 3, 16'h1234, 2'b00, 6'h1, '1, 0, 0);
        drive(1, 1, 3, 16'h1234, 2'b00, 6'h1, '1, 0, 0);
        idle(1);

        // Single route to port 3, then a second B to port 3 is unexpected
        drive(0, 0, 0, 16'h0, 2'b00, 6'h0, '1, 1, 3);
        drive(0, 1, 3, 16'h00A5, 2'b00, 6'h15, '1, 0, 0);
        idle(1);
        drive(0, 1, 3, 16'h00A6, 2'b00, 6'h0, '1, 0, 0);
        idle(2);

        // Back-pressure on port 2 with port 5 waiting
        drive(0, 0, 0, 16'h0, 2'b00, 6'h0, '1, 1, 2);
        drive(0, 0, 0, 16'h0, 2'b00, 6'h0, '1, 1, 5);
        drive(0, 1, 2, 16'h0222, 2'b10, 6'h22, hold2, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 5, 16'h0555, 2'b11, 6'h35, hold2, 0, 0);
        drive(0, 1, 5, 16'h0555, 2'b11, 6'h35, '1, 0, 0);
        idle(2);

        // Unexpected responses: zero count, and a nonexistent port index
        drive(0, 1, 4, 16'h0444, 2'b00, 6'h4, '1, 0, 0);
        drive(0, 1, 7, 16'h0777, 2'b01, 6'h7, '1, 0, 0);
        idle(2);

        // Fill port 0, overflow, simultaneous push and B at the limit, then drain
        for (int i = 0; i < MAXO; i++) drive(0, 0, 0, 16'h0, 2'b00, 6'h0, '1, 1, 0);
        drive(0, 0, 0, 16'h0, 2'b00, 6'h0, '1, 1, 0);
        drive(0, 1, 0, 16'h0F00, 2'b00, 6'h0, '1, 1, 0);
        drive(0, 0, 0, 16'h0, 2'b00, 6'h0, '1, 1, 7);
        for (int i = 0; i < MAXO + 1; i++) drive(0, 1, 0, 16'(i), 2'(i), 6'(i), '1, 0, 0);
        idle(1);

        // Reset while a response for port 1 is held
        drive(0, 0, 0, 16'h0, 2'b00, 6'h0, '1, 1, 1);
        drive(0, 1, 1, 16'h0111, 2'b01, 6'h11, '0, 0, 0);
        drive(0, 0, 0, 16'h0, 2'b00, 6'h0, '0, 0, 0);
        drive(1, 0, 0, 16'h0, 2'b00, 6'h0, '0, 0, 0);
        drive(0, 0, 0, 16'h0, 2'b00, 6'h0, '1, 0, 0);
        drive(0, 1, 1, 16'h0112, 2'b00, 6'h0, '1, 0, 0);
        idle(2);

        // Randomized traffic with phases biasing push rate and back-pressure
        for (int i = 0; i < 4000; i++) begin
            int phase;
            int port;
            int awp;
            phase = (i / 250) % 3;
            port  = ($urandom_range(0, 15) == 0) ? 7 : int'($urandom_range(0, NP - 1));
            awp   = ($urandom_range(0, 31) == 0) ? 7 : int'($urandom_range(0, NP - 1));
            drive(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 3) < ((phase == 0) ? 1 : 3)),
                  port, 16'($urandom), 2'($urandom), 6'($urandom),
                  (phase == 2) ? NP'($urandom) : ~NP'($urandom_range(0, 1) << $urandom_range(0, 6)),
                  ($urandom_range(0, 3) < ((phase == 0) ? 3 : 2)),
                  (phase == 0 && $urandom_range(0, 1) == 0) ? 0 : awp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
